// File: rtl/fifo_share_pkg.sv
// Shared types and width helpers for the shared-FIFO write/read controller.
// The helpers let sibling arbiters size their index, level and burst fields the same way.
package fifo_share_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Width of a requester index; a lone requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int burst_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap-around.
// Shared with other arbiters, so it carries no state of its own.
module rr_picker
    import fifo_share_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          any_valid_o
);

    int   idx_s;
    logic found_s;

    // Scan requests from ptr_i upward, wrapping at N, and keep the first one found.
    always_comb begin
        winner_o    = '0;
        found_s     = 1'b0;
        idx_s       = 0;
        any_valid_o = |req_i;
        for (int k = 0; k < N; k++) begin
            idx_s = (int'(ptr_i) + k) % N;
            if (!found_s && req_i[idx_s]) begin
                winner_o = IW'(idx_s);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

endmodule

// File: rtl/fifo_share_ctrl.sv
// Shares one synchronous FIFO between NUM_REQ producers (round-robin, bounded bursts)
// and one valid/ready consumer; beats are tagged with their source ID.
module fifo_share_ctrl
    import fifo_share_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATAWIDTH = 32,
    parameter int  DEPTH     = 8,
    parameter int  MAX_BURST = 4,
    localparam int IDW       = idx_width(NUM_REQ),
    localparam int CW        = level_width(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           fifo_write_en,
    output logic [DATAWIDTH+IDW-1:0]       fifo_write_data,
    input  logic                           fifo_full,
    output logic                           fifo_read_en,
    input  logic [DATAWIDTH+IDW-1:0]       fifo_read_data,
    input  logic                           fifo_empty,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATAWIDTH-1:0]           out_data,
    output logic [IDW-1:0]                 out_id,
    output logic [CW-1:0]                  level
);

    localparam int BCW = burst_width(MAX_BURST);

    state_e               state_q,     state_d;
    logic [IDW-1:0]       grant_id_q,  grant_id_d;
    logic [IDW-1:0]       rr_ptr_q,    rr_ptr_d;
    logic [BCW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [CW-1:0]        level_q,     level_d;
    logic [NUM_REQ-1:0]   grant_q,     grant_d;

    logic [IDW-1:0]       win_s;
    logic                 any_s;
    logic                 own_valid_s;
    logic                 accept_s;
    logic                 last_beat_s;
    logic                 rd_s;
    logic [IDW-1:0]       next_ptr_s;
    logic [DATAWIDTH-1:0] payload_s;

    rr_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .winner_o    (win_s),
        .any_valid_o (any_s)
    );

    assign own_valid_s = req_valid[grant_id_q];
    // Gating on fifo_full (not level) keeps a same-cycle pop from letting a write through.
    assign accept_s    = (state_q == BURST) & own_valid_s & ~fifo_full & ~rst;
    assign last_beat_s = (burst_cnt_q == BCW'(MAX_BURST - 1));
    assign rd_s        = out_ready & ~fifo_empty & ~rst;
    assign next_ptr_s  = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

    // Select the current owner's payload and raise its ready on an accepted beat.
    always_comb begin
        payload_s = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                payload_s    = req_data[i*DATAWIDTH +: DATAWIDTH];
                req_ready[i] = accept_s;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    assign fifo_write_en   = accept_s;
    assign fifo_write_data = {grant_id_q, payload_s};
    assign fifo_read_en    = rd_s;
    assign out_valid       = ~fifo_empty;
    assign {out_id, out_data} = fifo_read_data;
    assign grant           = grant_q;
    assign level           = level_q;

    // Arbitration and burst bookkeeping; releasing always advances the pointer past the owner.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d        = BURST;
                    grant_id_d     = win_s;
                    burst_cnt_d    = '0;
                    grant_d        = '0;
                    grant_d[win_s] = 1'b1;
                end else begin
                    grant_d = '0;
                end
            end
            BURST: begin
                if (!own_valid_s || (accept_s && last_beat_s)) begin
                    state_d     = IDLE;
                    rr_ptr_d    = next_ptr_s;
                    burst_cnt_d = '0;
                    grant_d     = '0;
                end else if (accept_s) begin
                    burst_cnt_d = burst_cnt_q + BCW'(1);
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
                grant_d     = '0;
            end
        endcase
    end

    // Occupancy tracks the strobes actually issued to the FIFO.
    always_comb begin
        case ({accept_s, rd_s})
            2'b10:   level_d = level_q + CW'(1);
            2'b01:   level_d = level_q - CW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            level_q     <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            level_q     <= level_d;
            grant_q     <= grant_d;
        end
    end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Bench for fifo_share_ctrl: behavioural FIFO, transaction-level arbitration model and
// scoreboard, directed scenarios followed by randomized traffic with occasional resets.
module tb_fifo_share_ctrl;

    localparam int NUM_REQ   = 4;
    localparam int DATAWIDTH = 32;
    localparam int DEPTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;
    localparam int CW        = 4;
    localparam int FW        = DATAWIDTH + IDW;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATAWIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           grant;
    logic                         fifo_write_en;
    logic [FW-1:0]                fifo_write_data;
    logic                         fifo_full;
    logic                         fifo_read_en;
    logic [FW-1:0]                fifo_read_data;
    logic                         fifo_empty;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATAWIDTH-1:0]         out_data;
    logic [IDW-1:0]               out_id;
    logic [CW-1:0]                level;

    int checks   = 0;
    int failures = 0;

    fifo_share_ctrl #(
        .NUM_REQ   (NUM_REQ),
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .grant           (grant),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .fifo_full       (fifo_full),
        .fifo_read_en    (fifo_read_en),
        .fifo_read_data  (fifo_read_data),
        .fifo_empty      (fifo_empty),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_id          (out_id),
        .level           (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural FIFO with combinational head
    logic [FW-1:0] fmem [DEPTH];
    int unsigned   f_wp  = 0;
    int unsigned   f_rp  = 0;
    int unsigned   f_cnt = 0;

    assign fifo_full      = (f_cnt == DEPTH);
    assign fifo_empty     = (f_cnt == 0);
    assign fifo_read_data = fmem[f_rp];

    always @(posedge clk) begin
        if (rst) begin
            f_wp  <= 0;
            f_rp  <= 0;
            f_cnt <= 0;
        end else begin
            if (fifo_write_en && f_cnt != DEPTH) begin
                fmem[f_wp] <= fifo_write_data;
                f_wp       <= (f_wp + 1) % DEPTH;
            end
            if (fifo_read_en && f_cnt != 0)
                f_rp <= (f_rp + 1) % DEPTH;
            f_cnt <= f_cnt + ((fifo_write_en && f_cnt != DEPTH) ? 1 : 0)
                           - ((fifo_read_en && f_cnt != 0) ? 1 : 0);
        end
    end

    // Reference model: owner (-1 when idle), next-start pointer, beats done, expected contents
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_beats = 0;
    logic [FW-1:0] sb[$];

    logic                rr_mode = 1'b0;
    int                  rr_runs = 0;
    logic [NUM_REQ-1:0]  prev_grant = '0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] e_ready;
        logic               e_wr;
        logic               e_rd;
        logic [FW-1:0]      e_wdata;
        int                 pick;

        check("grant", 64'(grant), (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
        check("level", 64'(level), 64'(sb.size()));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_id", 64'(out_id), 64'(sb[0][FW-1 -: IDW]));
            check("out_data", 64'(out_data), 64'(sb[0][DATAWIDTH-1:0]));
        end

        e_ready = '0;
        e_wr    = 1'b0;
        e_rd    = 1'b0;
        e_wdata = '0;
        if (!rst) begin
            e_rd = out_ready && (sb.size() != 0);
            if (m_owner >= 0 && req_valid[m_owner] && sb.size() < DEPTH) begin
                e_wr             = 1'b1;
                e_ready[m_owner] = 1'b1;
                e_wdata = {IDW'(m_owner), req_data[m_owner*DATAWIDTH +: DATAWIDTH]};
            end
        end
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("fifo_write_en", 64'(fifo_write_en), 64'(e_wr));
        check("fifo_read_en", 64'(fifo_read_en), 64'(e_rd));
        if (e_wr)
            check("fifo_write_data", 64'(fifo_write_data), 64'(e_wdata));

        if (rr_mode && grant != '0 && grant != prev_grant) begin
            check("rr_order", 64'(grant), 64'd1 << (rr_runs % NUM_REQ));
            rr_runs++;
        end
        prev_grant = grant;

        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_beats = 0;
            sb.delete();
        end else begin
            if (e_rd) void'(sb.pop_front());
            if (e_wr) sb.push_back(e_wdata);
            if (m_owner < 0) begin
                pick = -1;
                for (int k = 0; k < NUM_REQ; k++)
                    if (pick < 0 && req_valid[(m_ptr + k) % NUM_REQ])
                        pick = (m_ptr + k) % NUM_REQ;
                if (pick >= 0) begin
                    m_owner = pick;
                    m_beats = 0;
                end
            end else if (!req_valid[m_owner]) begin
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
            end else if (e_wr) begin
                m_beats++;
                if (m_beats == MAX_BURST) begin
                    m_ptr   = (m_owner + 1) % NUM_REQ;
                    m_owner = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            req_data[i*DATAWIDTH +: DATAWIDTH] = $urandom();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            req_data[i*DATAWIDTH +: DATAWIDTH] = $urandom();
        tick();
        tick();
        rst = 1'b0;

        // Round-robin with everybody streaming
        rr_mode   = 1'b1;
        out_ready = 1'b1;
        repeat (30) tick();
        rr_mode = 1'b0;
        check("rr_runs", 64'(rr_runs >= 5), 64'd1);
        req_valid = '0;
        repeat (10) tick();

        // Early release: requester 2 alone, two beats
        apply_reset();
        req_valid = 4'b0100;
        out_ready = 1'b0;
        repeat (3) tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        check("early_level", 64'(level), 64'd2);
        check("early_grant", 64'(grant), 64'd0);
        req_valid = '1;
        tick();
        req_valid = '0;
        @(negedge clk);
        check("early_next_grant", 64'(grant), 64'b1000);
        tick();

        // Full stall and resume
        apply_reset();
        req_valid = 4'b0011;
        out_ready = 1'b0;
        repeat (16) tick();
        @(negedge clk);
        check("full_level", 64'(level), 64'd8);
        check("full_no_write", 64'(fifo_write_en), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("pop_level", 64'(level), 64'd7);
        tick();
        @(negedge clk);
        check("resume_level", 64'(level), 64'd8);
        req_valid = '0;
        out_ready = 1'b1;
        repeat (12) tick();

        // Simultaneous write and read at level 4
        apply_reset();
        req_valid = 4'b0001;
        out_ready = 1'b0;
        repeat (5) tick();
        req_valid = 4'b0010;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("simul_level", 64'(level), 64'd4);
        out_ready = 1'b1;
        repeat (8) tick();

        // Reset during requester 1's second beat
        req_valid = 4'b0010;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1010;
        tick();
        @(negedge clk);
        check("midrst_grant", 64'(grant), 64'b0010);
        check("midrst_level", 64'(level), 64'd0);
        req_valid = '0;
        repeat (3) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 3) == 0)
                    req_valid[i] = $urandom_range(0, 1) == 1;
            out_ready = (c % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        check("drain_level", 64'(level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
